simd_pe_burst: RTL and testbench
================================

// Module: simd_pe_burst
// PURPOSE
//  Parametrised SIMD processing element for the multiprocessor's shared-memory fabric.
//  - Accepts a 4-instruction setup sequence from the issuer: LD A, LD B, INFO, STORE.
//  - Then streams operand vectors from shared memory, applies a lane-wise op and writes results back.
//  - Generalised lane count and element width; adds MOV mode, partial-beat masking and an abort path.
// PARAMETERS
//  LANES   4   SIMD lanes per beat
//  ELEM_W  16  bits per lane element; BUS_W = LANES*ELEM_W
//  ADDR_W  16  shared-memory element address width
//  CNT_W   16  element count width
//  PL_W    32  instruction payload width; must be >= max(ADDR_W, CNT_W+2)
// PORTS
//  i_clk       in   1                   clock
//  i_rstn      in   1                   synchronous active-low reset
//  i_en        in   1                   start setup from IDLE
//  i_abort     in   1                   abandon current command
//  i_valid     in   1                   instruction valid; also flush-ack in DONE
//  i_opcode    in   2                   0 LD, 1 INFO, 2 STORE, 3 reserved
//  i_payload   in   PL_W                address (LD/STORE) or {count[CNT_W-1:0], op[1:0]} (INFO)
//  o_ack       out  1                   1-cycle pulse: instruction accepted
//  o_req_rd    out  1                   read request
//  i_grant_rd  in   1                   read grant; i_rd_data valid same cycle
//  o_rd_addr   out  ADDR_W              read address
//  i_rd_data   in   BUS_W               read data
//  o_req_wr    out  1                   write request
//  i_grant_wr  in   1                   write grant
//  o_wr_addr   out  ADDR_W              write address
//  o_wr_data   out  BUS_W               result beat; lane 0 in LSBs
//  o_wr_size   out  $clog2(LANES+1)     valid lanes in beat
//  o_busy      out  1                   state != IDLE
//  o_finish    out  1                   state == DONE
// BEHAVIOUR
//  Reset (i_rstn=0 at posedge): state IDLE; all outputs 0; internal addresses, count and op cleared.
//  Setup states: IDLE -> LD0 -> LD1 -> INFO -> STORE.
//  - Each setup state advances only when i_valid and i_opcode match the expected opcode.
//  - Mismatched opcode: ignored, no ack, state held.
//  - LD0 latches addr_a; LD1 latches addr_b; INFO latches op and count; STORE latches addr_w.
//  - o_ack pulses on the cycle after each acceptance.
//  IDLE -> LD0 when i_en=1.
//  STORE accept: to RD0, or to DONE if count==0 (no memory traffic).
//  Datapath loop per beat: RD0 -> RD1 -> EXEC -> WR.
//  - RD0 and RD1 hold o_req_rd and o_rd_addr (addr_a / addr_b) until i_grant_rd, then capture i_rd_data.
//  - EXEC: 1 cycle; registers the result into o_wr_data.
//  - WR: holds o_req_wr, o_wr_addr, o_wr_data and o_wr_size stable until i_grant_wr.
//  - Minimum 4 cycles per beat with grants tied high.
//  Op per lane, modulo 2^ELEM_W: 0 add, 1 sub (A-B), 2 mul (low ELEM_W bits of product), 3 MOV (A).
//  Remaining count and o_wr_size:
//  - o_wr_size = min(rem, LANES).
//  - Lanes >= o_wr_size are forced to 0 in o_wr_data.
//  On write grant:
//  - addr_a, addr_b and addr_w each advance by LANES (wrap modulo 2^ADDR_W).
//  - If rem <= LANES: go to DONE. Else rem -= LANES and go to RD0.
//  DONE: o_finish=1 until i_valid=1, then IDLE (o_finish drops the next cycle).
//  i_abort=1 in any non-IDLE state: next state IDLE; requests drop the next cycle; no o_finish pulse.
//  i_abort has priority over grants in the same cycle.
//  Grant without request is ignored. Grant in the same cycle a request first rises counts as accepted.
//  Reset mid-operation: identical to power-on reset; in-flight beat is discarded.
// TESTING
//  T1 LANES=4, ELEM_W=16, setup A=0x10, B=0x20, op=0 count=4, W=0x30, grants high.
//     -> single write to 0x30, size 4, sums; o_finish until i_valid.
//  T2 op=1, count=10.
//     -> 3 writes at W, W+4, W+8 with sizes 4, 4, 2; lanes 2-3 of the last beat are 0.
//  T3 op=2, A lanes 0x0100, B lanes 0x0100.
//     -> result lanes 0x0000 (wrap); op=3 returns A unchanged.
//  T4 wrong opcode (STORE while in LD0).
//     -> no ack, state held; a later LD is accepted with ack on the next cycle.
//  T5 i_grant_wr withheld 5 cycles.
//     -> o_req_wr, o_wr_addr and o_wr_data stable throughout; i_abort in RD1 -> IDLE, o_busy=0 next cycle.
//  T6 count=0.
//     -> STORE goes straight to DONE with no o_req_rd/o_req_wr; reset asserted during WR -> all outputs 0.

Source files
------------

// File: rtl/simd_pe_burst.sv
// SIMD processing element: accepts an LD/LD/INFO/STORE setup sequence, then streams
// operand beats from shared memory, applies a lane-wise op and writes each result beat back.
module simd_pe_burst #(
  parameter  int LANES  = 4,
  parameter  int ELEM_W = 16,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 16,
  parameter  int PL_W   = 32,
  localparam int BUS_W  = LANES * ELEM_W,
  localparam int SZ_W   = $clog2(LANES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_abort,
  input  logic              i_valid,
  input  logic [1:0]        i_opcode,
  input  logic [PL_W-1:0]   i_payload,
  output logic              o_ack,
  output logic              o_req_rd,
  input  logic              i_grant_rd,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [BUS_W-1:0]  i_rd_data,
  output logic              o_req_wr,
  input  logic              i_grant_wr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [BUS_W-1:0]  o_wr_data,
  output logic [SZ_W-1:0]   o_wr_size,
  output logic              o_busy,
  output logic              o_finish
);

  localparam logic [1:0]        OPC_LD     = 2'd0;
  localparam logic [1:0]        OPC_INFO   = 2'd1;
  localparam logic [1:0]        OPC_STORE  = 2'd2;
  localparam logic [CNT_W-1:0]  LANES_CNT  = CNT_W'(LANES);
  localparam logic [ADDR_W-1:0] LANES_ADDR = ADDR_W'(LANES);

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_INFO, S_STORE, S_RD0, S_RD1, S_EXEC, S_WR, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_w;
  logic [CNT_W-1:0]  rem;
  logic [1:0]        op;
  logic              ack;
  logic              accept;
  logic              wr_done;
  logic              last_beat;
  logic [SZ_W-1:0]   size_c;
  logic [BUS_W-1:0]  opa_p0, opb_p0;
  logic [BUS_W-1:0]  res_c;
  logic [BUS_W-1:0]  wr_data_p1;
  logic              unused_payload;

  // Arithmetic is modulo 2^ELEM_W, so only the low half of the product is kept.
  function automatic logic [ELEM_W-1:0] lane_op(input logic signed [ELEM_W-1:0] a,
                                                input logic signed [ELEM_W-1:0] b,
                                                input logic [1:0]               sel);
    logic signed [2*ELEM_W-1:0] prod;
    prod = a * b;
    case (sel)
      2'd0:    lane_op = a + b;
      2'd1:    lane_op = a - b;
      2'd2:    lane_op = prod[ELEM_W-1:0];
      default: lane_op = a;
    endcase
  endfunction

  assign size_c    = (rem >= LANES_CNT) ? SZ_W'(LANES) : SZ_W'(rem);
  assign last_beat = (rem <= LANES_CNT);
  assign wr_done   = (state == S_WR) && i_grant_wr && !i_abort;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (state != S_IDLE && i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_en) state_nxt = S_LD0;
        S_LD0:   if (i_valid && i_opcode == OPC_LD) begin
                   accept    = 1'b1;
                   state_nxt = S_LD1;
                 end
        S_LD1:   if (i_valid && i_opcode == OPC_LD) begin
                   accept    = 1'b1;
                   state_nxt = S_INFO;
                 end
        S_INFO:  if (i_valid && i_opcode == OPC_INFO) begin
                   accept    = 1'b1;
                   state_nxt = S_STORE;
                 end
        // rem already holds the count latched in INFO.
        S_STORE: if (i_valid && i_opcode == OPC_STORE) begin
                   accept    = 1'b1;
                   state_nxt = (rem == '0) ? S_DONE : S_RD0;
                 end
        S_RD0:   if (i_grant_rd) state_nxt = S_RD1;
        S_RD1:   if (i_grant_rd) state_nxt = S_EXEC;
        S_EXEC:  state_nxt = S_WR;
        S_WR:    if (i_grant_wr) state_nxt = last_beat ? S_DONE : S_RD0;
        S_DONE:  if (i_valid) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= S_IDLE;
      ack        <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_w     <= '0;
      rem        <= '0;
      op         <= '0;
      wr_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      ack   <= accept;
      if (accept) begin
        case (state)
          S_LD0:   addr_a <= i_payload[ADDR_W-1:0];
          S_LD1:   addr_b <= i_payload[ADDR_W-1:0];
          S_INFO:  begin
                     rem <= i_payload[CNT_W+1:2];
                     op  <= i_payload[1:0];
                   end
          S_STORE: addr_w <= i_payload[ADDR_W-1:0];
          default: ;
        endcase
      end
      if (state == S_EXEC) wr_data_p1 <= res_c;
      if (wr_done) begin
        addr_a <= addr_a + LANES_ADDR;
        addr_b <= addr_b + LANES_ADDR;
        addr_w <= addr_w + LANES_ADDR;
        if (!last_beat) rem <= rem - LANES_CNT;
      end
    end
  end

  // ---- stage p0: operand capture on read grant
  always_ff @(posedge i_clk) begin
    if (state == S_RD0 && i_grant_rd) opa_p0 <= i_rd_data;
    if (state == S_RD1 && i_grant_rd) opb_p0 <= i_rd_data;
  end

  // ---- stage p1: lane ops with partial-beat masking, registered in EXEC
  always_comb begin
    res_c = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l < int'(size_c))
        res_c[l*ELEM_W +: ELEM_W] = lane_op(opa_p0[l*ELEM_W +: ELEM_W],
                                            opb_p0[l*ELEM_W +: ELEM_W], op);
    end
  end

  assign unused_payload = ^i_payload;

  assign o_ack     = ack;
  assign o_req_rd  = (state == S_RD0) || (state == S_RD1);
  assign o_rd_addr = (state == S_RD0) ? addr_a : (state == S_RD1) ? addr_b : '0;
  assign o_req_wr  = (state == S_WR);
  assign o_wr_addr = (state == S_WR) ? addr_w : '0;
  assign o_wr_data = wr_data_p1;
  assign o_wr_size = (state == S_WR) ? size_c : '0;
  assign o_busy    = (state != S_IDLE);
  assign o_finish  = (state == S_DONE);

endmodule

// File: tb/tb_simd_pe_burst.sv
// Bench for simd_pe_burst: random memory/grants, expected read/write beats computed
// from a plain per-command model, plus literal expectations for directed cases.
module tb_simd_pe_burst;
  localparam int LANES = 4, ELEM_W = 16, BUS_W = 64;

  logic        clk = 1'b0;
  logic        i_rstn = 1'b0, i_en = 1'b0, i_abort = 1'b0, i_valid = 1'b0;
  logic [1:0]  i_opcode = '0;
  logic [31:0] i_payload = '0;
  logic        i_grant_rd = 1'b0, i_grant_wr = 1'b0;
  logic [63:0] i_rd_data = '0;
  logic        o_ack, o_req_rd, o_req_wr, o_busy, o_finish;
  logic [15:0] o_rd_addr, o_wr_addr;
  logic [63:0] o_wr_data;
  logic [2:0]  o_wr_size;

  simd_pe_burst dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_en(i_en), .i_abort(i_abort), .i_valid(i_valid),
    .i_opcode(i_opcode), .i_payload(i_payload), .o_ack(o_ack), .o_req_rd(o_req_rd),
    .i_grant_rd(i_grant_rd), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_req_wr(o_req_wr), .i_grant_wr(i_grant_wr), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_wr_size(o_wr_size), .o_busy(o_busy), .o_finish(o_finish)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [2:0]  ws_q[$];
  logic [63:0] wd_q[$];
  bit          chk_en = 1'b0;
  int          hold_wr = 0;
  bit          rd_blk_en = 1'b0;
  logic [15:0] rd_blk = '0;
  int          n_wr = 0, n_rd_req = 0, n_wr_req = 0, stall = 0, stall_max = 0;
  logic [15:0] last_wa;
  logic [2:0]  last_ws;
  logic [63:0] last_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b, input int op);
    logic [31:0] p;
    p = a * b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return p[15:0];
      default: return a;
    endcase
  endfunction

  function automatic logic [63:0] beat(input logic [15:0] addr);
    logic [63:0] r;
    logic [15:0] x;
    for (int l = 0; l < LANES; l++) begin
      x = addr + 16'(l);
      r[l*ELEM_W +: ELEM_W] = mem[x];
    end
    return r;
  endfunction

  // Expected read addresses and write beats for one whole command.
  task automatic build_model(input logic [15:0] a, input logic [15:0] b, input int op,
                             input int cnt, input logic [15:0] w);
    int r, k, sz;
    logic [15:0] ab, bb, ia, ib;
    logic [63:0] d;
    r = cnt; k = 0;
    while (r > 0) begin
      sz = (r < LANES) ? r : LANES;
      ab = a + 16'(LANES * k);
      bb = b + 16'(LANES * k);
      d = '0;
      for (int l = 0; l < sz; l++) begin
        ia = ab + 16'(l);
        ib = bb + 16'(l);
        d[l*ELEM_W +: ELEM_W] = ref_op(mem[ia], mem[ib], op);
      end
      rd_q.push_back(ab);
      rd_q.push_back(bb);
      wa_q.push_back(w + 16'(LANES * k));
      ws_q.push_back(3'(sz));
      wd_q.push_back(d);
      r -= LANES;
      k++;
    end
  endtask

  // Memory/grant responder and per-cycle output checker.
  always @(negedge clk) begin
    bit g;
    if (!chk_en) begin
      i_grant_rd = 1'b0;
      i_grant_wr = 1'b0;
    end else begin
      if (o_req_rd) begin
        n_rd_req++;
        i_rd_data = beat(o_rd_addr);
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got addr %h expected no read", o_rd_addr);
        end else chk("rd_addr", 64'(o_rd_addr), 64'(rd_q[0]));
        g = ($urandom_range(0, 3) != 0) && !(rd_blk_en && o_rd_addr == rd_blk);
        i_grant_rd = g;
        if (g && rd_q.size() > 0) void'(rd_q.pop_front());
      end else begin
        i_grant_rd = 1'($urandom_range(0, 1));
      end
      if (o_req_wr) begin
        n_wr_req++;
        if (wa_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got addr %h expected no write", o_wr_addr);
        end else chk("wr_beat", {o_wr_addr, 5'd0, o_wr_size, o_wr_data[39:0]},
                     {wa_q[0], 5'd0, ws_q[0], wd_q[0][39:0]});
        if (wd_q.size() > 0) chk("wr_data", o_wr_data, wd_q[0]);
        if (hold_wr > 0) begin
          hold_wr--;
          g = 1'b0;
        end else g = ($urandom_range(0, 3) != 0);
        i_grant_wr = g;
        if (g) begin
          stall = 0;
          n_wr++;
          last_wa = o_wr_addr; last_ws = o_wr_size; last_wd = o_wr_data;
          if (wa_q.size() > 0) begin
            void'(wa_q.pop_front()); void'(ws_q.pop_front()); void'(wd_q.pop_front());
          end
        end else begin
          stall++;
          if (stall > stall_max) stall_max = stall;
        end
      end else begin
        i_grant_wr = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send(input logic [1:0] opc, input logic [31:0] pl, input logic exp_ack);
    @(negedge clk);
    i_valid = 1'b1; i_opcode = opc; i_payload = pl;
    @(negedge clk);
    i_valid = 1'b0;
    chk("ack", 64'(o_ack), 64'(exp_ack));
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] b, input int op,
                       input int cnt, input logic [15:0] w, input bit bad_first);
    logic [15:0] c16;
    c16 = 16'(cnt);
    build_model(a, b, op, cnt, w);
    @(negedge clk); i_en = 1'b1;
    @(negedge clk); i_en = 1'b0;
    chk("busy_start", 64'(o_busy), 64'd1);
    if (bad_first) begin
      send(2'd2, 32'h55, 1'b0);
      chk("busy_held", 64'(o_busy), 64'd1);
    end
    send(2'd0, {16'd0, a}, 1'b1);
    send(2'd0, {16'd0, b}, 1'b1);
    send(2'd1, {14'd0, c16, 2'(op)}, 1'b1);
    send(2'd2, {16'd0, w}, 1'b1);
  endtask

  task automatic finish_cmd();
    for (int c = 0; c < 3000 && !o_finish; c++) @(negedge clk);
    chk("finish", 64'(o_finish), 64'd1);
    chk("wr_left", 64'(wa_q.size()), 64'd0);
    chk("rd_left", 64'(rd_q.size()), 64'd0);
    @(negedge clk);
    chk("finish_hold", 64'(o_finish), 64'd1);
    i_valid = 1'b1; i_opcode = 2'd0;
    @(negedge clk);
    i_valid = 1'b0;
    chk("finish_drop", {62'd0, o_finish, o_busy}, 64'd0);
  endtask

  task automatic clear_model();
    rd_q.delete(); wa_q.delete(); ws_q.delete(); wd_q.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return {o_ack, o_req_rd, o_req_wr, o_busy, o_finish, o_wr_size, o_rd_addr, o_wr_addr} ^
           64'(o_wr_data != 0);
  endfunction

  initial begin
    int nw0, nr0, nq0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_data", o_wr_data, 64'd0);
    i_rstn = 1'b1;
    chk_en = 1'b1;

    // T1: four-lane add, single beat
    for (int l = 0; l < 4; l++) mem[16'h10 + l] = 16'(l + 1);
    mem[16'h20] = 16'h10; mem[16'h21] = 16'h20; mem[16'h22] = 16'h30; mem[16'h23] = 16'hFFFF;
    nw0 = n_wr;
    setup(16'h10, 16'h20, 0, 4, 16'h30, 1'b0);
    finish_cmd();
    chk("t1_nwr", 64'(n_wr - nw0), 64'd1);
    chk("t1_addr", 64'(last_wa), 64'h30);
    chk("t1_size", 64'(last_ws), 64'd4);
    chk("t1_data", last_wd, 64'h0003_0033_0022_0011);

    // T2: sub over 10 elements, partial last beat
    nw0 = n_wr;
    setup(16'h40, 16'h50, 1, 10, 16'h60, 1'b0);
    finish_cmd();
    chk("t2_nwr", 64'(n_wr - nw0), 64'd3);
    chk("t2_addr", 64'(last_wa), 64'h68);
    chk("t2_size", 64'(last_ws), 64'd2);
    chk("t2_mask", 64'(last_wd[63:32]), 64'd0);

    // T3: mul wraparound, then MOV
    for (int l = 0; l < 4; l++) begin
      mem[16'h100 + l] = 16'h0100; mem[16'h110 + l] = 16'h0100; mem[16'h130 + l] = 16'h1234;
    end
    setup(16'h100, 16'h110, 2, 4, 16'h120, 1'b0);
    finish_cmd();
    chk("t3_mul", last_wd, 64'd0);
    setup(16'h100, 16'h130, 3, 4, 16'h140, 1'b0);
    finish_cmd();
    chk("t3_mov", last_wd, 64'h0100_0100_0100_0100);

    // T4: STORE offered in LD0 is ignored
    setup(16'h70, 16'h80, 0, 3, 16'h90, 1'b1);
    finish_cmd();

    // T5: write grant withheld, then abort in RD1
    stall_max = 0;
    hold_wr = 5;
    setup(16'h200, 16'h210, 0, 6, 16'h220, 1'b0);
    finish_cmd();
    chk("t5_stall", 64'(stall_max >= 5), 64'd1);
    rd_blk = 16'h310; rd_blk_en = 1'b1;
    setup(16'h300, 16'h310, 1, 8, 16'h320, 1'b0);
    for (int c = 0; c < 200 && !(o_req_rd && o_rd_addr == 16'h310); c++) @(negedge clk);
    chk("t5_in_rd1", {47'd0, o_req_rd, o_rd_addr}, {47'd0, 1'b1, 16'h310});
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("t5_abort", {61'd0, o_busy, o_req_rd, o_finish}, 64'd0);
    rd_blk_en = 1'b0;
    clear_model();

    // T6: zero count, then reset during WR
    nr0 = n_rd_req; nq0 = n_wr_req;
    setup(16'h500, 16'h510, 0, 0, 16'h520, 1'b0);
    chk("t6_done", 64'(o_finish), 64'd1);
    finish_cmd();
    chk("t6_noreq", 64'((n_rd_req - nr0) + (n_wr_req - nq0)), 64'd0);
    hold_wr = 1000;
    setup(16'h600, 16'h610, 2, 4, 16'h620, 1'b0);
    for (int c = 0; c < 200 && !o_req_wr; c++) @(negedge clk);
    chk("t6_in_wr", 64'(o_req_wr), 64'd1);
    i_rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", all_outs(), 64'd0);
    chk("t6_rst_data", o_wr_data, 64'd0);
    i_rstn = 1'b1;
    hold_wr = 0;
    clear_model();

    // Random commands, including address wrap at the top of memory
    setup(16'hFFFE, 16'hFFFA, 0, 7, 16'hFFFD, 1'b0);
    finish_cmd();
    for (int n = 0; n < 14; n++) begin
      setup(16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(1, 13),
            16'($urandom), 1'b0);
      finish_cmd();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
